// File: rtl/vcache_stat_snapshot_serializer_pkg.sv
// Shared definitions for the vcache statistics snapshot serializer.
//   - record geometry (7 words, 4 event counters)
//   - record word index enum
//   - serializer FSM state enum
package vcache_stat_snapshot_serializer_pkg;

    localparam int vcache_stat_rec_words_gp = 7;
    localparam int vcache_stat_num_ctrs_gp  = 4;

    // Word positions inside one snapshot record.
    typedef enum logic [2:0] {
        e_rec_inst_id    = 3'd0,
        e_rec_global_ctr = 3'd1,
        e_rec_tag        = 3'd2,
        e_rec_ld         = 3'd3,
        e_rec_st         = 3'd4,
        e_rec_ld_miss    = 3'd5,
        e_rec_st_miss    = 3'd6
    } vcache_stat_rec_idx_e;

    typedef enum logic {
        e_state_idle = 1'b0,
        e_state_send = 1'b1
    } vcache_stat_state_e;

    // Record word index of event counter number ctr (ld, st, ld_miss, st_miss).
    function automatic int rec_ctr_word(input int ctr);
        return int'(e_rec_ld) + ctr;
    endfunction

endpackage

// File: rtl/vcache_stat_snapshot_serializer_if.sv
// Record stream interface of the snapshot serializer.
//   v_o     record word valid        (master -> slave)
//   data_o  record word              (master -> slave)
//   last_o  marks the final word     (master -> slave)
//   ready_i downstream accepts word  (slave  -> master)
interface vcache_stat_snapshot_serializer_if #(
    parameter int data_width_p = 32
);
    logic                    v_o;
    logic [data_width_p-1:0] data_o;
    logic                    last_o;
    logic                    ready_i;

    modport master (output v_o, output data_o, output last_o, input ready_i);
    modport slave  (input v_o, input data_o, input last_o, output ready_i);
endinterface

// File: rtl/vcache_stat_snapshot_serializer_event_counter.sv
// One wrapping event counter.
//   clk_i    clock
//   reset_i  synchronous active-high reset, counter -> 0
//   inc_i    add one this cycle
//   clear_i  restart the count from this cycle's increment
//   count_o  running total including this cycle's increment (not cleared);
//            this is the value a snapshot taken this cycle must report
module vcache_event_counter #(
    parameter int width_p = 32
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               inc_i,
    input  logic               clear_i,
    output logic [width_p-1:0] count_o
);
    logic [width_p-1:0] r_count;
    logic [width_p-1:0] w_sum;
    logic [width_p-1:0] w_next;

    assign w_sum   = r_count + width_p'(inc_i);
    assign w_next  = clear_i ? width_p'(inc_i) : w_sum;
    assign count_o = w_sum;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_count <= '0;
        end else begin
            r_count <= w_next;
        end
    end
endmodule

// File: rtl/vcache_stat_snapshot_serializer.sv
// Per-vcache event counter bank with snapshot serializer.
// Counts loads, stores, load misses and store misses at the vcache accept
// point (v_i & yumi_i). A snapshot request freezes a 7-word record
// (instance id, global counter, tag, 4 counts) which is streamed one word
// per cycle over the stream interface.
//   clk_i, reset_i            clock, synchronous active-high reset
//   v_i, yumi_i               vcache output valid / consumed
//   miss_i, ld_op_i, st_op_i  access attributes in the output stage
//   global_ctr_i              free-running global cycle counter
//   snap_v_i, snap_tag_i      snapshot request and its tag
//   snap_ready_o              request accepted when snap_v_i & snap_ready_o
//   stream_if (master)        v_o / data_o / last_o / ready_i record stream
module vcache_stat_snapshot_serializer
    import vcache_stat_snapshot_serializer_pkg::*;
#(
    parameter int data_width_p    = 32,
    parameter int ctr_width_p     = 32,
    parameter int instance_id_p   = 0,
    parameter int clear_on_snap_p = 0
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    v_i,
    input  logic                    yumi_i,
    input  logic                    miss_i,
    input  logic                    ld_op_i,
    input  logic                    st_op_i,
    input  logic [data_width_p-1:0] global_ctr_i,
    input  logic                    snap_v_i,
    input  logic [data_width_p-1:0] snap_tag_i,
    output logic                    snap_ready_o,
    vcache_stat_snapshot_serializer_if.master stream_if
);
    localparam logic w_clear_en = (clear_on_snap_p != 0);

    vcache_stat_state_e      r_state;
    logic [2:0]              r_idx;
    logic                    r_v;
    logic                    r_last;
    logic [data_width_p-1:0] r_data;
    logic [data_width_p-1:0] r_rec [vcache_stat_rec_words_gp];

    logic                    w_acc;
    logic                    w_snap_accept;
    logic                    w_inc   [vcache_stat_num_ctrs_gp];
    logic [ctr_width_p-1:0]  w_count [vcache_stat_num_ctrs_gp];
    logic [data_width_p-1:0] w_rec   [vcache_stat_rec_words_gp];

    assign w_acc         = v_i & yumi_i;
    assign w_snap_accept = snap_v_i & (r_state == e_state_idle) & ~reset_i;

    assign w_inc[0] = w_acc & ld_op_i;
    assign w_inc[1] = w_acc & st_op_i;
    assign w_inc[2] = w_acc & ld_op_i & miss_i;
    assign w_inc[3] = w_acc & st_op_i & miss_i;

    assign w_rec[e_rec_inst_id]    = data_width_p'(instance_id_p);
    assign w_rec[e_rec_global_ctr] = global_ctr_i;
    assign w_rec[e_rec_tag]        = snap_tag_i;

    // Counters keep running in every state; the record captures the
    // accumulated value including the accept-cycle event, while a clearing
    // counter restarts from that same event.
    genvar gi;
    generate
        for (gi = 0; gi < vcache_stat_num_ctrs_gp; gi++) begin : g_ctr
            vcache_event_counter #(
                .width_p (ctr_width_p)
            ) u_ctr (
                .clk_i   (clk_i),
                .reset_i (reset_i),
                .inc_i   (w_inc[gi]),
                .clear_i (w_snap_accept & w_clear_en),
                .count_o (w_count[gi])
            );
            assign w_rec[rec_ctr_word(gi)] = data_width_p'(w_count[gi]);
        end
    endgenerate

    // Frozen record storage; only rewritten when a new snapshot is accepted.
    always_ff @(posedge clk_i) begin
        if (w_snap_accept) begin
            for (int i = 0; i < vcache_stat_rec_words_gp; i++) begin
                r_rec[i] <= w_rec[i];
            end
        end
    end

    // Serializer FSM; r_data always holds r_rec[r_idx] while sending, so the
    // word stays stable under back-pressure.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= e_state_idle;
            r_idx   <= '0;
            r_v     <= 1'b0;
            r_last  <= 1'b0;
            r_data  <= '0;
        end else begin
            case (r_state)
                e_state_idle: begin
                    if (snap_v_i) begin
                        r_state <= e_state_send;
                        r_idx   <= '0;
                        r_v     <= 1'b1;
                        r_last  <= 1'b0;
                        r_data  <= w_rec[e_rec_inst_id];
                    end
                end
                e_state_send: begin
                    if (stream_if.ready_i) begin
                        if (r_idx == e_rec_st_miss) begin
                            r_state <= e_state_idle;
                            r_idx   <= '0;
                            r_v     <= 1'b0;
                            r_last  <= 1'b0;
                            r_data  <= '0;
                        end else begin
                            r_idx  <= r_idx + 3'd1;
                            r_data <= r_rec[r_idx + 3'd1];
                            r_last <= ((r_idx + 3'd1) == e_rec_st_miss);
                        end
                    end
                end
                default: begin
                    r_state <= e_state_idle;
                end
            endcase
        end
    end

    // Outputs are forced quiet while reset is asserted.
    assign snap_ready_o     = (r_state == e_state_idle) & ~reset_i;
    assign stream_if.v_o    = r_v & ~reset_i;
    assign stream_if.last_o = r_last & ~reset_i;
    assign stream_if.data_o = reset_i ? '0 : r_data;

endmodule
